// File: rtl/ahb_burst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_burst_sequencer_pkg
//  Description : Shared AHB encodings, widths and sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_burst_sequencer_pkg;

  localparam int AHB_ADDR_WIDTH   = 32;
  localparam int AHB_DATA_WIDTH   = 32;
  localparam int AHB_1KB_BOUNDARY = 1024;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } ahb_burst_e;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } ahb_trans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE       = 3'd0,
    SIZE_HALFWORD   = 3'd1,
    SIZE_WORD       = 3'd2,
    SIZE_DOUBLEWORD = 3'd3,
    SIZE_LINE4      = 3'd4,
    SIZE_LINE8      = 3'd5,
    SIZE_LINE16     = 3'd6,
    SIZE_LINE32     = 3'd7
  } ahb_size_e;

  typedef enum logic {
    XFER_READ  = 1'b0,
    XFER_WRITE = 1'b1
  } ahb_write_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } ahb_resp_e;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_ADDR   = 2'd1,
    SEQ_BUSY   = 2'd2,
    SEQ_CANCEL = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/ahb_burst_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_burst_addr_gen
//  Description : Combinational next-beat address, beat count and 1 KB
//                crossing detection for the current AHB beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_burst_addr_gen
  import ahb_burst_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = AHB_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_burst,
  input  logic [2:0]            i_size,
  input  logic [4:0]            i_len,
  output logic [ADDR_WIDTH-1:0] o_next_addr,
  output logic [4:0]            o_beats,
  output logic                  o_cross_1k
);

  localparam int KB_BITS = $clog2(AHB_1KB_BOUNDARY);

  logic [ADDR_WIDTH-1:0] w_inc;
  logic [ADDR_WIDTH-1:0] w_incr_addr;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic [2:0]            w_wrap_log2;
  logic                  w_is_wrap;

  // Beat count per burst type; wrapping bursts also report log2 of their beat count
  always_comb begin
    o_beats     = 5'd1;
    w_is_wrap   = 1'b0;
    w_wrap_log2 = 3'd0;
    unique case (ahb_burst_e'(i_burst))
      BURST_SINGLE: o_beats = 5'd1;
      BURST_INCR:   o_beats = i_len;
      BURST_WRAP4:  begin o_beats = 5'd4;  w_is_wrap = 1'b1; w_wrap_log2 = 3'd2; end
      BURST_INCR4:  o_beats = 5'd4;
      BURST_WRAP8:  begin o_beats = 5'd8;  w_is_wrap = 1'b1; w_wrap_log2 = 3'd3; end
      BURST_INCR8:  o_beats = 5'd8;
      BURST_WRAP16: begin o_beats = 5'd16; w_is_wrap = 1'b1; w_wrap_log2 = 3'd4; end
      BURST_INCR16: o_beats = 5'd16;
    endcase
  end

  assign w_inc       = ADDR_WIDTH'(1) << i_size;
  assign w_incr_addr = i_addr + w_inc;
  // Wrap window is beats*inc bytes; both are powers of two so a shift suffices
  assign w_wrap_mask = (w_inc << w_wrap_log2) - ADDR_WIDTH'(1);
  assign o_next_addr = w_is_wrap ? ((i_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask))
                                 : w_incr_addr;
  // A wrapping burst stays inside its own window, so only incrementing bursts restart
  assign o_cross_1k  = !w_is_wrap && (w_incr_addr[KB_BITS-1:0] == '0);

endmodule
`default_nettype wire

// File: rtl/ahb_burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_burst_sequencer
//  Description : AHB master address-phase controller. Takes one burst command
//                at a time and drives NONSEQ/SEQ/BUSY/IDLE with registered
//                HADDR/HTRANS/HBURST/HSIZE/HWRITE, honouring HREADY stalls and
//                cancelling the burst on an ERROR response.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_burst_sequencer
  import ahb_burst_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = AHB_ADDR_WIDTH,
  parameter int DATA_WIDTH = AHB_DATA_WIDTH,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_burst,
  input  logic [2:0]            cmd_size,
  input  logic                  cmd_write,
  input  logic [4:0]            cmd_len,
  input  logic [MAX_BEATS-1:0]  cmd_busy_mask,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic [2:0]            hburst,
  output logic [2:0]            hsize,
  output logic                  hwrite,
  input  logic                  hready,
  input  logic                  hresp,
  output logic                  beat_accept,
  output logic                  burst_done,
  output logic                  burst_err
);

  seq_state_e            r_state,      w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_haddr,      w_haddr_nxt;
  ahb_trans_e            r_htrans,     w_htrans_nxt;
  logic [2:0]            r_hburst,     w_hburst_nxt;
  logic [2:0]            r_hsize,      w_hsize_nxt;
  logic                  r_hwrite,     w_hwrite_nxt;
  logic [4:0]            r_len,        w_len_nxt;
  logic [MAX_BEATS-1:0]  r_busy_mask,  w_mask_nxt;
  logic [4:0]            r_cnt,        w_cnt_nxt;
  logic                  r_pend_ns,    w_pend_ns_nxt;
  logic                  r_accept,     w_accept_nxt;
  logic                  r_done,       w_done_nxt;
  logic                  r_err,        w_err_nxt;

  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH-1:0] w_cmd_aligned;
  logic [4:0]            w_beats;
  logic [4:0]            w_cnt_inc;
  logic                  w_cross_1k;
  logic                  w_busy_next;
  logic                  w_cmd_illegal;

  ahb_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .i_addr      (r_haddr),
    .i_burst     (r_hburst),
    .i_size      (r_hsize),
    .i_len       (r_len),
    .o_next_addr (w_next_addr),
    .o_beats     (w_beats),
    .o_cross_1k  (w_cross_1k)
  );

  assign cmd_ready     = (r_state == SEQ_IDLE);
  assign w_cmd_aligned = cmd_addr & ~((ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1));
  assign w_cmd_illegal = (int'(32'd8 << cmd_size) > DATA_WIDTH)
                      || ((ahb_burst_e'(cmd_burst) == BURST_INCR)
                          && ((cmd_len == 5'd0) || (int'(cmd_len) > MAX_BEATS)));
  assign w_cnt_inc     = r_cnt + 5'd1;
  assign w_busy_next   = |(r_busy_mask & (MAX_BEATS'(1) << w_cnt_inc));

  // Next-state and next-output computation; every register holds unless an event moves it
  always_comb begin
    w_state_nxt   = r_state;
    w_haddr_nxt   = r_haddr;
    w_htrans_nxt  = r_htrans;
    w_hburst_nxt  = r_hburst;
    w_hsize_nxt   = r_hsize;
    w_hwrite_nxt  = r_hwrite;
    w_len_nxt     = r_len;
    w_mask_nxt    = r_busy_mask;
    w_cnt_nxt     = r_cnt;
    w_pend_ns_nxt = r_pend_ns;
    w_accept_nxt  = 1'b0;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    unique case (r_state)
      SEQ_IDLE: begin
        w_htrans_nxt = HTRANS_IDLE;
        if (cmd_valid) begin
          if (w_cmd_illegal) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt  = SEQ_ADDR;
            w_haddr_nxt  = w_cmd_aligned;
            w_htrans_nxt = HTRANS_NONSEQ;
            w_hburst_nxt = cmd_burst;
            w_hsize_nxt  = cmd_size;
            w_hwrite_nxt = cmd_write;
            w_len_nxt    = cmd_len;
            w_mask_nxt   = cmd_busy_mask;
            w_cnt_nxt    = 5'd0;
          end
        end
      end
      SEQ_ADDR: begin
        if (hready) begin
          w_accept_nxt = 1'b1;
          w_cnt_nxt    = w_cnt_inc;
          if (w_cnt_inc == w_beats) begin
            w_done_nxt   = 1'b1;
            w_state_nxt  = SEQ_IDLE;
            w_htrans_nxt = HTRANS_IDLE;
          end else begin
            w_haddr_nxt = w_next_addr;
            if (w_busy_next) begin
              // Remember whether the beat after the BUSY must restart as NONSEQ
              w_state_nxt   = SEQ_BUSY;
              w_htrans_nxt  = HTRANS_BUSY;
              w_pend_ns_nxt = w_cross_1k;
            end else if (w_cross_1k) begin
              w_htrans_nxt = HTRANS_NONSEQ;
            end else begin
              w_htrans_nxt = HTRANS_SEQ;
            end
          end
        end else if (hresp == RESP_ERROR) begin
          w_state_nxt  = SEQ_CANCEL;
          w_htrans_nxt = HTRANS_IDLE;
          w_err_nxt    = 1'b1;
        end
      end
      SEQ_BUSY: begin
        if (hready) begin
          w_state_nxt = SEQ_ADDR;
          if (r_pend_ns) w_htrans_nxt = HTRANS_NONSEQ;
          else           w_htrans_nxt = HTRANS_SEQ;
        end else if (hresp == RESP_ERROR) begin
          w_state_nxt  = SEQ_CANCEL;
          w_htrans_nxt = HTRANS_IDLE;
          w_err_nxt    = 1'b1;
        end
      end
      SEQ_CANCEL: begin
        w_state_nxt  = SEQ_IDLE;
        w_htrans_nxt = HTRANS_IDLE;
      end
      default: w_state_nxt = SEQ_IDLE;
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state     <= SEQ_IDLE;
      r_haddr     <= '0;
      r_htrans    <= HTRANS_IDLE;
      r_hburst    <= BURST_SINGLE;
      r_hsize     <= SIZE_BYTE;
      r_hwrite    <= XFER_READ;
      r_len       <= 5'd0;
      r_busy_mask <= '0;
      r_cnt       <= 5'd0;
      r_pend_ns   <= 1'b0;
      r_accept    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_haddr     <= w_haddr_nxt;
      r_htrans    <= w_htrans_nxt;
      r_hburst    <= w_hburst_nxt;
      r_hsize     <= w_hsize_nxt;
      r_hwrite    <= w_hwrite_nxt;
      r_len       <= w_len_nxt;
      r_busy_mask <= w_mask_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend_ns   <= w_pend_ns_nxt;
      r_accept    <= w_accept_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign haddr       = r_haddr;
  assign htrans      = r_htrans;
  assign hburst      = r_hburst;
  assign hsize       = r_hsize;
  assign hwrite      = r_hwrite;
  assign beat_accept = r_accept;
  assign burst_done  = r_done;
  assign burst_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ahb_burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_burst_sequencer
//  Description : Self-checking bench for ahb_burst_sequencer. A burst-level
//                reference model expands each command into its expected beat
//                list; the driver walks that list cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_burst_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 16;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  burst;
    logic [2:0]  size;
    logic        write;
    logic [4:0]  len;
    logic [15:0] mask;
  } cmd_t;

  logic          hclk = 1'b0;
  logic          hreset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_burst;
  logic [2:0]    cmd_size;
  logic          cmd_write;
  logic [4:0]    cmd_len;
  logic [MB-1:0] cmd_busy_mask;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [2:0]    hburst;
  logic [2:0]    hsize;
  logic          hwrite;
  logic          hready;
  logic          hresp;
  logic          beat_accept;
  logic          burst_done;
  logic          burst_err;

  ahb_burst_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) u_dut (
    .hclk          (hclk),
    .hreset        (hreset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_burst     (cmd_burst),
    .cmd_size      (cmd_size),
    .cmd_write     (cmd_write),
    .cmd_len       (cmd_len),
    .cmd_busy_mask (cmd_busy_mask),
    .haddr         (haddr),
    .htrans        (htrans),
    .hburst        (hburst),
    .hsize         (hsize),
    .hwrite        (hwrite),
    .hready        (hready),
    .hresp         (hresp),
    .beat_accept   (beat_accept),
    .burst_done    (burst_done),
    .burst_err     (burst_err)
  );

  always #5 hclk = ~hclk;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] exp_addr[$];
  logic [1:0]  exp_trans[$];
  cmd_t        g_next;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_beats(input cmd_t c);
    case (c.burst)
      3'd0:       return 1;
      3'd1:       return int'(c.len);
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  function automatic bit ref_illegal(input cmd_t c);
    return ((8 << c.size) > DW) || (c.burst == 3'd1 && (c.len == 0 || int'(c.len) > MB));
  endfunction

  function automatic void ref_build(input cmd_t c);
    longint unsigned a, inc, bound, base;
    int  n;
    bit  wrap;
    n     = ref_beats(c);
    wrap  = (c.burst == 3'd2) || (c.burst == 3'd4) || (c.burst == 3'd6);
    inc   = 64'd1 << c.size;
    a     = {32'd0, c.addr};
    a     = a - (a % inc);
    bound = inc * longint'(n);
    exp_addr.delete();
    exp_trans.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(a[31:0]);
      if (i == 0 || (!wrap && (a % 1024) == 0)) exp_trans.push_back(T_NONSEQ);
      else                                      exp_trans.push_back(T_SEQ);
      if (wrap) begin
        base = a - (a % bound);
        a    = base + ((a - base + inc) % bound);
      end else begin
        a = (a + inc) % (64'd1 << 32);
      end
    end
  endfunction

  function automatic cmd_t mk_cmd(input logic [31:0] addr, input logic [2:0] burst, input logic [2:0] size,
                                  input logic write, input logic [4:0] len, input logic [15:0] mask);
    cmd_t c;
    c.addr = addr; c.burst = burst; c.size = size; c.write = write; c.len = len; c.mask = mask;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.burst = 3'($urandom_range(7));
    c.size  = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
    c.len   = ($urandom_range(9) == 0) ? (($urandom_range(1) == 0) ? 5'd0 : 5'd17) : 5'($urandom_range(16, 1));
    c.addr  = $urandom;
    if ($urandom_range(2) == 0) c.addr = (c.addr & 32'hFFFF_FC00) | (32'h3C0 + 32'($urandom_range(63)));
    c.write = 1'($urandom_range(1));
    c.mask  = 16'($urandom);
    return c;
  endfunction

  task automatic drive_cmd(input cmd_t c);
    cmd_valid     = 1'b1;
    cmd_addr      = c.addr;
    cmd_burst     = c.burst;
    cmd_size      = c.size;
    cmd_write     = c.write;
    cmd_len       = c.len;
    cmd_busy_mask = c.mask;
  endtask

  // Runs one command; called and returns at a falling edge
  task automatic run_burst(input cmd_t c, input int ready_pct, input int stall_beat, input int stall_cycles,
                           input int err_beat, input bit overlap);
    int n, b, stalls, guard;
    bit in_busy, prev_acc, prev_last, done, illegal;
    n       = ref_beats(c);
    illegal = ref_illegal(c);
    if (!illegal) ref_build(c);
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge hclk);
      guard++;
    end
    if (!cmd_ready) begin
      check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      return;
    end
    drive_cmd(c);
    hready = 1'b1;
    hresp  = 1'b0;
    @(negedge hclk);
    cmd_valid = 1'b0;
    check_eq("cmd_ready_after_cmd", 32'(cmd_ready), 32'(illegal));
    check_eq("err_after_cmd", 32'(burst_err), 32'(illegal));
    if (illegal) begin
      check_eq("htrans_illegal", 32'(htrans), 32'(T_IDLE));
      check_eq("accept_illegal", 32'(beat_accept), 32'd0);
      return;
    end
    b = 0; in_busy = 0; prev_acc = 0; prev_last = 0; stalls = 0; guard = 0; done = 0;
    while (!done && guard < 600) begin
      check_eq("beat_accept", 32'(beat_accept), 32'(prev_acc));
      check_eq("burst_done", 32'(burst_done), 32'(prev_acc && prev_last));
      check_eq("burst_err", 32'(burst_err), 32'd0);
      if (prev_last) begin
        check_eq("htrans_after_last", 32'(htrans), 32'(T_IDLE));
        check_eq("cmd_ready_after_last", 32'(cmd_ready), 32'd1);
        done = 1;
        break;
      end
      check_eq("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      check_eq("htrans", 32'(htrans), in_busy ? 32'(T_BUSY) : 32'(exp_trans[b]));
      check_eq("haddr", haddr, exp_addr[b]);
      check_eq("hburst", 32'(hburst), 32'(c.burst));
      check_eq("hsize", 32'(hsize), 32'(c.size));
      check_eq("hwrite", 32'(hwrite), 32'(c.write));
      if (b == err_beat) begin
        hready = 1'b0;
        hresp  = 1'b1;
        @(negedge hclk);
        check_eq("err_htrans", 32'(htrans), 32'(T_IDLE));
        check_eq("err_pulse", 32'(burst_err), 32'd1);
        check_eq("err_no_done", 32'(burst_done), 32'd0);
        check_eq("err_no_accept", 32'(beat_accept), 32'd0);
        check_eq("err_cancel_ready", 32'(cmd_ready), 32'd0);
        hready = 1'b1;
        hresp  = 1'b1;
        @(negedge hclk);
        hresp = 1'b0;
        check_eq("err_ready_back", 32'(cmd_ready), 32'd1);
        check_eq("err_idle_held", 32'(htrans), 32'(T_IDLE));
        check_eq("err_pulse_once", 32'(burst_err), 32'd0);
        return;
      end
      if (overlap && !in_busy && b == n - 1) drive_cmd(g_next);
      if (!in_busy && b == stall_beat && stalls < stall_cycles) begin
        hready = 1'b0;
        stalls++;
      end else begin
        hready = ($urandom_range(99) < ready_pct);
      end
      hresp = 1'b0;
      @(negedge hclk);
      guard++;
      prev_acc  = 0;
      prev_last = 0;
      if (hready) begin
        if (in_busy) begin
          in_busy = 0;
        end else begin
          prev_acc = 1;
          b++;
          if (b == n) prev_last = 1;
          else        in_busy = c.mask[b];
        end
      end
    end
    hready = 1'b1;
    if (!done) check_eq("burst_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    cmd_t c;
    int   pct, eb;
    bit   ov;
    hreset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_burst = '0; cmd_size = '0;
    cmd_write = 1'b0; cmd_len = '0; cmd_busy_mask = '0; hready = 1'b1; hresp = 1'b0;
    repeat (3) @(negedge hclk);
    check_eq("rst_haddr", haddr, 32'd0);
    check_eq("rst_htrans", 32'(htrans), 32'(T_IDLE));
    check_eq("rst_hburst", 32'(hburst), 32'd0);
    check_eq("rst_hsize", 32'(hsize), 32'd0);
    check_eq("rst_hwrite", 32'(hwrite), 32'd0);
    check_eq("rst_pulses", {29'd0, beat_accept, burst_done, burst_err}, 32'd0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    hreset = 1'b0;
    @(negedge hclk);

    // INCR4 WORD at 0x100, with the WRAP4 at 0x38 presented during its last beat
    g_next = mk_cmd(32'h38, 3'd2, 3'd2, 1'b0, 5'd0, 16'h0);
    run_burst(mk_cmd(32'h100, 3'd3, 3'd2, 1'b1, 5'd0, 16'h0), 100, -1, 0, -1, 1'b1);
    run_burst(g_next, 100, -1, 0, -1, 1'b0);
    // INCR8 HALFWORD, two-cycle stall on beat 3, BUSY before beat 5
    run_burst(mk_cmd(32'h20, 3'd5, 3'd1, 1'b0, 5'd0, 16'h0020), 100, 3, 2, -1, 1'b0);
    // INCR len 3 across the 1 KB boundary
    run_burst(mk_cmd(32'h3F8, 3'd1, 3'd2, 1'b1, 5'd3, 16'h0), 100, -1, 0, -1, 1'b0);
    // INCR16 cancelled by ERROR on beat 2
    run_burst(mk_cmd(32'h1000, 3'd7, 3'd2, 1'b1, 5'd0, 16'h0), 100, -1, 0, 2, 1'b0);
    // Illegal commands: oversize transfer, INCR length 0 and MAX_BEATS+1
    run_burst(mk_cmd(32'h80, 3'd3, 3'd3, 1'b0, 5'd0, 16'h0), 100, -1, 0, -1, 1'b0);
    run_burst(mk_cmd(32'h80, 3'd1, 3'd2, 1'b0, 5'd0, 16'h0), 100, -1, 0, -1, 1'b0);
    run_burst(mk_cmd(32'h80, 3'd1, 3'd0, 1'b0, 5'd17, 16'h0), 100, -1, 0, -1, 1'b0);
    // INCR len 16 of bytes at the top of the address space wraps modulo 2^32
    run_burst(mk_cmd(32'hFFFF_FFF8, 3'd1, 3'd0, 1'b0, 5'd16, 16'h0), 100, -1, 0, -1, 1'b0);

    // Reset in the middle of an INCR8 write burst
    drive_cmd(mk_cmd(32'h500, 3'd5, 3'd2, 1'b1, 5'd0, 16'h0));
    hready = 1'b1;
    @(negedge hclk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge hclk);
    check_eq("mid_htrans", 32'(htrans), 32'(T_SEQ));
    check_eq("mid_haddr", haddr, 32'h508);
    hreset = 1'b1;
    @(negedge hclk);
    check_eq("mrst_haddr", haddr, 32'd0);
    check_eq("mrst_htrans", 32'(htrans), 32'(T_IDLE));
    check_eq("mrst_hburst", 32'(hburst), 32'd0);
    check_eq("mrst_hsize", 32'(hsize), 32'd0);
    check_eq("mrst_hwrite", 32'(hwrite), 32'd0);
    check_eq("mrst_pulses", {29'd0, beat_accept, burst_done, burst_err}, 32'd0);
    hreset = 1'b0;
    @(negedge hclk);
    check_eq("mrst_ready", 32'(cmd_ready), 32'd1);
    check_eq("mrst_quiet", {29'd0, beat_accept, burst_done, burst_err}, 32'd0);
    check_eq("mrst_idle", 32'(htrans), 32'(T_IDLE));

    // Randomized commands, stalls, BUSY masks, errors and back-to-back issue
    g_next = rand_cmd();
    for (int i = 0; i < 60; i++) begin
      c      = g_next;
      g_next = rand_cmd();
      pct    = $urandom_range(100, 40);
      ov     = 1'($urandom_range(1));
      eb     = ($urandom_range(5) == 0) ? $urandom_range(ref_beats(c) > 0 ? ref_beats(c) - 1 : 0) : -1;
      run_burst(c, pct, -1, 0, eb, ov);
    end
    cmd_valid = 1'b0;
    repeat (2) @(negedge hclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
